// File: rtl/pattern_scan_ctrl.sv
// Word-to-serial sequencer feeding a programmable Moore pattern matcher.
// Counts matches per word and returns the count over a valid/ready handshake.
module pattern_scan_ctrl #(
    parameter  int WORD_W = 8,
    parameter  int PAT_W  = 4,
    parameter  int CNT_W  = 4,
    localparam int LEN_W  = $clog2(PAT_W) + 1,
    localparam int IDX_W  = $clog2(WORD_W)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              cfg_we,
    input  logic [PAT_W-1:0]  cfg_pattern,
    input  logic [LEN_W-1:0]  cfg_len,
    input  logic              cfg_overlap,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [WORD_W-1:0] in_word,
    output logic              ser_bit,
    output logic              det,
    output logic              busy,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [CNT_W-1:0]  out_count
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SHIFT  = 2'd1,
        REPORT = 2'd2
    } state_t;

    state_t              state_r, state_s;
    logic [WORD_W-1:0]   word_r;
    logic [IDX_W-1:0]    idx_r;
    logic [PAT_W-1:0]    hist_r, hist_s;
    logic [LEN_W-1:0]    fill_r, fill_s;
    logic [CNT_W-1:0]    cnt_r, cnt_s;
    logic [PAT_W-1:0]    pat_r;
    logic [LEN_W-1:0]    len_r;
    logic                ovl_r;
    logic                det_r, ser_bit_r, in_ready_r, busy_r, out_valid_r;
    logic                cur_bit_s, match_s;
    logic [LEN_W:0]      fill_inc_s;

    // Out-of-range lengths collapse to the full pattern width.
    function automatic logic [LEN_W-1:0] norm_len(input logic [LEN_W-1:0] l);
        if ((l == {LEN_W{1'b0}}) || (l > LEN_W'(PAT_W)))
            return LEN_W'(PAT_W);
        else
            return l;
    endfunction

    function automatic logic [PAT_W-1:0] len_mask(input logic [LEN_W-1:0] l);
        logic [PAT_W-1:0] m;
        for (int i = 0; i < PAT_W; i++)
            m[i] = (i < int'(l));
        return m;
    endfunction

    // Matcher datapath: next history, fill, match and saturated count.
    always_comb begin
        cur_bit_s  = word_r[idx_r];
        hist_s     = {hist_r[PAT_W-2:0], cur_bit_s};
        fill_inc_s = {1'b0, fill_r} + {{LEN_W{1'b0}}, 1'b1};
        match_s    = (fill_inc_s >= {1'b0, len_r}) &&
                     (((hist_s ^ pat_r) & len_mask(len_r)) == {PAT_W{1'b0}});
        if (match_s && !ovl_r)
            fill_s = {LEN_W{1'b0}};
        else if (fill_r == LEN_W'(PAT_W))
            fill_s = fill_r;
        else
            fill_s = fill_r + {{(LEN_W-1){1'b0}}, 1'b1};
        if (cnt_r == {CNT_W{1'b1}})
            cnt_s = cnt_r;
        else
            cnt_s = cnt_r + {{(CNT_W-1){1'b0}}, 1'b1};
    end

    // Next-state logic.
    always_comb begin
        state_s = state_r;
        case (state_r)
            IDLE:    if (in_valid)                 state_s = SHIFT;  else state_s = IDLE;
            SHIFT:   if (idx_r == {IDX_W{1'b0}})   state_s = REPORT; else state_s = SHIFT;
            REPORT:  if (out_ready)                state_s = IDLE;   else state_s = REPORT;
            default: state_s = IDLE;
        endcase
    end

    // State register.
    always_ff @(posedge clk) begin
        if (rst)
            state_r <= IDLE;
        else
            state_r <= state_s;
    end

    // Datapath, configuration and registered status outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            word_r      <= {WORD_W{1'b0}};
            idx_r       <= {IDX_W{1'b0}};
            hist_r      <= {PAT_W{1'b0}};
            fill_r      <= {LEN_W{1'b0}};
            cnt_r       <= {CNT_W{1'b0}};
            pat_r       <= PAT_W'(3'b101);
            len_r       <= LEN_W'(3);
            ovl_r       <= 1'b1;
            det_r       <= 1'b0;
            ser_bit_r   <= 1'b0;
            in_ready_r  <= 1'b1;
            busy_r      <= 1'b0;
            out_valid_r <= 1'b0;
        end else begin
            in_ready_r  <= (state_s == IDLE);
            busy_r      <= (state_s != IDLE);
            out_valid_r <= (state_r == REPORT);
            case (state_r)
                IDLE: begin
                    det_r <= 1'b0;
                    if (cfg_we) begin
                        pat_r <= cfg_pattern;
                        len_r <= norm_len(cfg_len);
                        ovl_r <= cfg_overlap;
                    end
                    if (in_valid) begin
                        word_r <= in_word;
                        idx_r  <= IDX_W'(WORD_W - 1);
                        hist_r <= {PAT_W{1'b0}};
                        fill_r <= {LEN_W{1'b0}};
                        cnt_r  <= {CNT_W{1'b0}};
                    end
                end
                SHIFT: begin
                    ser_bit_r <= cur_bit_s;
                    hist_r    <= hist_s;
                    fill_r    <= fill_s;
                    det_r     <= match_s;
                    idx_r     <= idx_r - {{(IDX_W-1){1'b0}}, 1'b1};
                    if (match_s)
                        cnt_r <= cnt_s;
                end
                REPORT:  det_r <= 1'b0;
                default: det_r <= 1'b0;
            endcase
        end
    end

    assign in_ready  = in_ready_r;
    assign busy      = busy_r;
    assign out_valid = out_valid_r;
    assign out_count = cnt_r;
    assign det       = det_r;
    assign ser_bit   = ser_bit_r;

endmodule
